vscale_debug_sequencer: RTL and testbench

Sequences the core's debug-spec-0.13 halt/resume handshake and register-access port on behalf of the debug module. Sits between the debug module (abstract-command side) and `vscale_pipeline`'s `haltreq`/`haltack`/`resumereq`/`resumeack` and `register_index`/`debug_*` ports. It converts abstract commands into single core register accesses and returns responses with cmderr codes. It rejects accesses unless the hart is halted and times out unanswered halt requests.

---
 rtl/vscale_debug_sequencer_pkg.sv | 23 ++
 rtl/vscale_debug_regno_decode.sv | 22 ++
 rtl/vscale_debug_sequencer.sv | 160 ++++++++++++++++
 tb/tb_vscale_debug_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vscale_debug_sequencer_pkg.sv
// rtl/vscale_debug_sequencer_pkg.sv - shared types and constants for the debug sequencer
package vscale_debug_sequencer_pkg;

  localparam int XPR_LEN = 32;

  typedef enum logic [2:0] {
    ST_RUNNING,
    ST_HALT_REQ,
    ST_HALTED,
    ST_ACCESS,
    ST_WAIT_RD,
    ST_RESP,
    ST_RESUME_REQ
  } dbg_state_e;

  localparam logic [2:0] DBG_ERR_NONE       = 3'd0;
  localparam logic [2:0] DBG_ERR_NOTSUP     = 3'd2;
  localparam logic [2:0] DBG_ERR_HALTRESUME = 3'd4;

  localparam logic [15:0] DBG_REGNO_CSR = 16'h0000;
  localparam logic [15:0] DBG_REGNO_GPR = 16'h1000;

endpackage

// File: rtl/vscale_debug_regno_decode.sv
// rtl/vscale_debug_regno_decode.sv - abstract regno to core register_index decode
module vscale_debug_regno_decode
  import vscale_debug_sequencer_pkg::*;
(
  input  logic [15:0] regno,
  output logic [12:0] register_index,
  output logic        valid
);

  always_comb begin
    register_index = '0;
    valid          = 1'b0;
    if (regno[15:12] == DBG_REGNO_CSR[15:12]) begin
      register_index = {1'b0, regno[11:0]};
      valid          = 1'b1;
    end else if (regno[15:5] == DBG_REGNO_GPR[15:5]) begin
      register_index = {1'b1, 7'b0, regno[4:0]};
      valid          = 1'b1;
    end
  end

endmodule

// File: rtl/vscale_debug_sequencer.sv
// rtl/vscale_debug_sequencer.sv - halt/resume handshake and abstract register access sequencer
module vscale_debug_sequencer
  import vscale_debug_sequencer_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dm_haltreq,
  input  logic               dm_resumereq,
  output logic               dm_halted,
  output logic               dm_resumeack,
  output logic               dm_halt_timeout,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [15:0]        cmd_regno,
  input  logic [XPR_LEN-1:0] cmd_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [XPR_LEN-1:0] resp_data,
  output logic [2:0]         resp_err,
  output logic               haltreq,
  input  logic               haltack,
  output logic               resumereq,
  input  logic               resumeack,
  output logic [12:0]        register_index,
  output logic               debug_write,
  output logic               debug_read,
  output logic [XPR_LEN-1:0] debug_wdata,
  input  logic [XPR_LEN-1:0] debug_rdata
);

  localparam logic [15:0] HALT_LAST = 16'(HALT_TIMEOUT - 1);
  localparam logic [2:0]  RD_LAST   = 3'(READ_LATENCY - 1);

  dbg_state_e  state, state_nx;
  logic [15:0] halt_cnt;
  logic [2:0]  rd_cnt;
  logic        resume_pend;
  logic        ret_halted;
  logic        is_write;
  logic [12:0] dec_index;
  logic        dec_valid;
  logic        cmd_accept;
  logic        halt_expired;

  vscale_debug_regno_decode u_decode (
    .regno          (cmd_regno),
    .register_index (dec_index),
    .valid          (dec_valid)
  );

  assign cmd_accept   = cmd_valid && cmd_ready;
  assign halt_expired = (halt_cnt >= HALT_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      ST_RUNNING: begin
        if (cmd_accept)      state_nx = ST_RESP;
        else if (dm_haltreq) state_nx = ST_HALT_REQ;
      end
      ST_HALT_REQ: begin
        if (haltack)           state_nx = ST_HALTED;
        else if (halt_expired) state_nx = ST_RUNNING;
      end
      ST_HALTED: begin
        if (cmd_accept)                        state_nx = dec_valid ? ST_ACCESS : ST_RESP;
        else if (resume_pend || dm_resumereq)  state_nx = ST_RESUME_REQ;
      end
      ST_ACCESS:     state_nx = is_write ? ST_RESP : ST_WAIT_RD;
      ST_WAIT_RD:    if (rd_cnt == RD_LAST) state_nx = ST_RESP;
      ST_RESP:       if (resp_ready) state_nx = ret_halted ? ST_HALTED : ST_RUNNING;
      ST_RESUME_REQ: if (resumeack) state_nx = ST_RUNNING;
      default:       state_nx = ST_RUNNING;
    endcase
  end

  // Outputs are registered from the next state so each strobe lines up with its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_RUNNING;
      halt_cnt        <= '0;
      rd_cnt          <= '0;
      resume_pend     <= 1'b0;
      ret_halted      <= 1'b0;
      is_write        <= 1'b0;
      cmd_ready       <= 1'b0;
      haltreq         <= 1'b0;
      resumereq       <= 1'b0;
      resp_valid      <= 1'b0;
      debug_write     <= 1'b0;
      debug_read      <= 1'b0;
      dm_halted       <= 1'b0;
      dm_resumeack    <= 1'b0;
      dm_halt_timeout <= 1'b0;
      resp_data       <= '0;
      resp_err        <= DBG_ERR_NONE;
      register_index  <= '0;
      debug_wdata     <= '0;
    end else begin
      state           <= state_nx;
      cmd_ready       <= (state_nx == ST_RUNNING) || (state_nx == ST_HALTED);
      haltreq         <= (state_nx == ST_HALT_REQ);
      resumereq       <= (state_nx == ST_RESUME_REQ);
      resp_valid      <= (state_nx == ST_RESP);
      debug_write     <= (state_nx == ST_ACCESS) && cmd_write;
      debug_read      <= (state_nx == ST_ACCESS) && !cmd_write;
      dm_halt_timeout <= (state == ST_HALT_REQ) && !haltack && halt_expired;
      dm_resumeack    <= (state == ST_RESUME_REQ) && resumeack;

      if ((state == ST_HALT_REQ) && haltack)
        dm_halted <= 1'b1;
      else if ((state == ST_RESUME_REQ) && resumeack)
        dm_halted <= 1'b0;

      if (state != ST_HALT_REQ)
        halt_cnt <= '0;
      else if (halt_cnt != 16'hFFFF)
        halt_cnt <= halt_cnt + 16'd1;

      rd_cnt <= (state == ST_WAIT_RD) ? rd_cnt + 3'd1 : 3'd0;

      if ((state == ST_WAIT_RD) && (rd_cnt == RD_LAST))
        resp_data <= debug_rdata;

      if (cmd_accept) begin
        ret_halted <= (state == ST_HALTED);
        is_write   <= cmd_write;
        resp_data  <= '0;
        if (state == ST_RUNNING) begin
          resp_err <= DBG_ERR_HALTRESUME;
        end else if (!dec_valid) begin
          resp_err <= DBG_ERR_NOTSUP;
        end else begin
          resp_err       <= DBG_ERR_NONE;
          register_index <= dec_index;
          debug_wdata    <= cmd_wdata;
        end
      end else if ((state == ST_RESP) && resp_ready) begin
        resp_err       <= DBG_ERR_NONE;
        resp_data      <= '0;
        register_index <= '0;
        debug_wdata    <= '0;
      end

      // A resume arriving mid-access waits until the hart is back in HALTED.
      if (state_nx == ST_RESUME_REQ)
        resume_pend <= 1'b0;
      else if (dm_resumereq &&
               ((state == ST_ACCESS) || (state == ST_WAIT_RD) ||
                ((state == ST_RESP) && ret_halted) ||
                ((state == ST_HALTED) && cmd_accept)))
        resume_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vscale_debug_sequencer.sv
// tb/tb_vscale_debug_sequencer.sv - directed self-checking bench for vscale_debug_sequencer
module tb_vscale_debug_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        dm_haltreq, dm_resumereq, dm_halted, dm_resumeack, dm_halt_timeout;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_regno;
  logic [31:0] cmd_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic [2:0]  resp_err;
  logic        haltreq, haltack, resumereq, resumeack;
  logic [12:0] register_index;
  logic        debug_write, debug_read;
  logic [31:0] debug_wdata, debug_rdata;

  int n_cmp = 0;
  int n_err = 0;

  vscale_debug_sequencer #(.READ_LATENCY(2), .HALT_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .dm_haltreq(dm_haltreq), .dm_resumereq(dm_resumereq), .dm_halted(dm_halted),
    .dm_resumeack(dm_resumeack), .dm_halt_timeout(dm_halt_timeout),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_regno(cmd_regno), .cmd_wdata(cmd_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .haltreq(haltreq), .haltack(haltack), .resumereq(resumereq), .resumeack(resumeack),
    .register_index(register_index), .debug_write(debug_write), .debug_read(debug_read),
    .debug_wdata(debug_wdata), .debug_rdata(debug_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; dm_haltreq = 1'b0; dm_resumereq = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_regno = 16'h0; cmd_wdata = 32'h0;
    resp_ready = 1'b0; haltack = 1'b0; resumeack = 1'b0; debug_rdata = 32'h0;
    tick(); tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_haltreq", 32'(haltreq), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_halted", 32'(dm_halted), 32'd0);
    chk("rst_strobes", 32'({debug_read, debug_write, resumereq}), 32'd0);
    chk("rst_index", 32'(register_index), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    // CSR read while running -> error 4, no core access
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_regno = 16'h0300;
    tick();
    cmd_valid = 1'b0;
    chk("run_rd_valid", 32'(resp_valid), 32'd1);
    chk("run_rd_err", 32'(resp_err), 32'd4);
    chk("run_rd_data", resp_data, 32'd0);
    chk("run_rd_noread", 32'(debug_read), 32'd0);
    chk("run_rd_ready", 32'(cmd_ready), 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("run_rd_done", 32'(resp_valid), 32'd0);
    chk("run_rd_back", 32'(cmd_ready), 32'd1);
    chk("run_rd_noread2", 32'(debug_read), 32'd0);

    // Halt with haltack after haltreq has been high 5 cycles
    dm_haltreq = 1'b1;
    tick();
    chk("halt_req", 32'(haltreq), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_hold", 32'({haltreq, dm_halted}), 32'b10);
    end
    haltack = 1'b1;
    tick();
    haltack = 1'b0; dm_haltreq = 1'b0;
    chk("halt_drop", 32'(haltreq), 32'd0);
    chk("halt_halted", 32'(dm_halted), 32'd1);
    chk("halt_ready", 32'(cmd_ready), 32'd1);

    // GPR write x5
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_regno = 16'h1005; cmd_wdata = 32'hDEADBEEF;
    tick();
    cmd_valid = 1'b0;
    chk("wr_strobe", 32'(debug_write), 32'd1);
    chk("wr_index", 32'(register_index), 32'h1005);
    chk("wr_wdata", debug_wdata, 32'hDEADBEEF);
    chk("wr_busy", 32'(cmd_ready), 32'd0);
    tick();
    chk("wr_strobe_off", 32'(debug_write), 32'd0);
    chk("wr_resp", 32'(resp_valid), 32'd1);
    chk("wr_err", 32'(resp_err), 32'd0);
    chk("wr_data", resp_data, 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("wr_done", 32'({resp_valid, cmd_ready}), 32'b01);

    // GPR read x5, data valid 2 cycles after debug_read
    cmd_valid = 1'b1; cmd_write = 1'b0; debug_rdata = 32'h12345678;
    tick();
    cmd_valid = 1'b0;
    chk("rd_strobe", 32'(debug_read), 32'd1);
    chk("rd_index", 32'(register_index), 32'h1005);
    chk("rd_nowrite", 32'(debug_write), 32'd0);
    tick();
    chk("rd_strobe_off", 32'(debug_read), 32'd0);
    chk("rd_wait1", 32'(resp_valid), 32'd0);
    tick();
    debug_rdata = 32'hDEADBEEF;
    chk("rd_wait2", 32'(resp_valid), 32'd0);
    tick();
    debug_rdata = 32'h12345678;
    chk("rd_resp", 32'(resp_valid), 32'd1);
    chk("rd_data", resp_data, 32'hDEADBEEF);
    chk("rd_err", 32'(resp_err), 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Unsupported regno while halted
    cmd_valid = 1'b1; cmd_regno = 16'h2000;
    tick();
    cmd_valid = 1'b0;
    chk("ns_resp", 32'(resp_valid), 32'd1);
    chk("ns_err", 32'(resp_err), 32'd2);
    chk("ns_strobes", 32'({debug_read, debug_write}), 32'd0);
    chk("ns_data", resp_data, 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("ns_done", 32'({cmd_ready, dm_halted}), 32'b11);

    // Resume arriving during WAIT_RD, response back-pressured 3 cycles
    cmd_valid = 1'b1; cmd_regno = 16'h0300;
    tick();
    cmd_valid = 1'b0;
    chk("rs_strobe", 32'(debug_read), 32'd1);
    chk("rs_index", 32'(register_index), 32'h0300);
    tick();
    dm_resumereq = 1'b1;
    tick();
    dm_resumereq = 1'b0; debug_rdata = 32'hCAFEF00D;
    chk("rs_no_resume_wait", 32'(resumereq), 32'd0);
    tick();
    debug_rdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      chk("rs_hold_valid", 32'(resp_valid), 32'd1);
      chk("rs_hold_data", resp_data, 32'hCAFEF00D);
      chk("rs_hold_noresume", 32'(resumereq), 32'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("rs_resp_done", 32'({resp_valid, resumereq, dm_halted}), 32'b001);
    tick();
    chk("rs_resumereq", 32'(resumereq), 32'd1);
    chk("rs_busy", 32'(cmd_ready), 32'd0);
    resumeack = 1'b1;
    tick();
    resumeack = 1'b0;
    chk("rs_ack_pulse", 32'(dm_resumeack), 32'd1);
    chk("rs_running", 32'({resumereq, dm_halted, cmd_ready}), 32'b001);
    tick();
    chk("rs_ack_end", 32'(dm_resumeack), 32'd0);

    // Halt timeout: dm_haltreq drops early, no haltack
    dm_haltreq = 1'b1;
    tick();
    dm_haltreq = 1'b0;
    chk("to_req", 32'(haltreq), 32'd1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("to_hold", 32'({haltreq, dm_halt_timeout}), 32'b10);
    end
    tick();
    chk("to_pulse", 32'(dm_halt_timeout), 32'd1);
    chk("to_state", 32'({haltreq, dm_halted, cmd_ready}), 32'b001);
    tick();
    chk("to_pulse_end", 32'({dm_halt_timeout, haltreq}), 32'd0);

    // Reset during an in-flight write
    dm_haltreq = 1'b1;
    tick();
    dm_haltreq = 1'b0; haltack = 1'b1;
    tick();
    haltack = 1'b0;
    chk("mr_halted", 32'(dm_halted), 32'd1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_regno = 16'h1001;
    tick();
    cmd_valid = 1'b0;
    chk("mr_strobe", 32'(debug_write), 32'd1);
    reset = 1'b1;
    tick();
    chk("mr_cleared", 32'({debug_write, resp_valid, dm_halted, cmd_ready}), 32'd0);
    chk("mr_index", 32'(register_index), 32'd0);
    reset = 1'b0;
    tick();
    chk("mr_ready", 32'({cmd_ready, resp_valid}), 32'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
